axilite_csr_write_bank: RTL and testbench

Parametrised AXI4-Lite write slave for the coprocessor CSR block: accepts AW, W and B channels independently, decodes a word address into a bank of `NUM_REGS` registers, and applies byte-strobed writes. Drives the register contents and a one-cycle per-register write pulse to the control datapath. Successor to the single-register write-data stage: it adds independent AW/W ordering, a B response channel, a configurable depth and width, and out-of-range detection.

---
 rtl/axilite_csr_write_bank.sv | 120 ++++++++++++
 tb/tb_axilite_csr_write_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_csr_write_bank.sv
// AXI4-Lite write slave driving a bank of byte-strobed CSRs with per-register write pulses.
// Define AXIL_CSR_WR_SLVERR_EN to answer out-of-range writes with SLVERR instead of OKAY.
module axilite_csr_write_bank #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 32,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_CSR_WR_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic [1:0] {COLLECT, COMMIT, RESP} state_t;

  state_t                       state;
  logic                         aw_held;
  logic                         w_held;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            data_q;
  logic [STRB_W-1:0]            strb_q;
  logic [NUM_REGS*DATA_W-1:0]   regs_q;
  logic [NUM_REGS-1:0]          pulse_q;
  logic                         bvalid_q;
  logic [1:0]                   bresp_q;
  logic [ADDR_W-1:0]            idx;
  logic                         in_range;
  logic                         aw_hs;
  logic                         w_hs;

  // Readies depend only on registered state, so no input reaches them combinationally.
  assign awready  = (state == COLLECT) && !aw_held;
  assign wready   = (state == COLLECT) && !w_held;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign idx      = addr_q >> LSB;
  assign in_range = idx < ADDR_W'(NUM_REGS);

  assign regs_out = regs_q;
  assign wr_pulse = pulse_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      regs_q   <= RESET_VAL;
      pulse_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      pulse_q <= '0;
      case (state)
        COLLECT: begin
          if (aw_hs) begin
            addr_q  <= awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            data_q <= wdata;
            strb_q <= wstrb;
            w_held <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs))
            state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (in_range && (idx == ADDR_W'(i))) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b])
                  regs_q[i*DATA_W + b*8 +: 8] <= data_q[b*8 +: 8];
              end
              pulse_q[i] <= |strb_q;
            end
          end
          bvalid_q <= 1'b1;
          bresp_q  <= in_range ? RESP_OKAY : RESP_OOR;
          state    <= RESP;
        end
        RESP: begin
          // Held flags clear only here, so a new AW/W cannot slip in before B completes.
          if (bready) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            state    <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_csr_write_bank.sv
// Scoreboard bench for axilite_csr_write_bank: directed cases then randomized writes
// checked against an array model of the register bank.
module tb_axilite_csr_write_bank;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 32;
  localparam logic [NR*DW-1:0] RV = {32'h7070_0707, 32'h6060_0606, 32'h5050_0505, 32'h4040_0404,
                                     32'h3030_0303, 32'h2020_0202, 32'h1010_0101, 32'h0F0F_F0F0};
`ifdef AXIL_CSR_WR_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic            clk;
  logic            rst;
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]   wr_pulse;

  axilite_csr_write_bank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .regs_out(regs_out), .wr_pulse(wr_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]       resp;
    logic [NR*DW-1:0] img;
    logic [NR-1:0]    pulse;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[NR];
  int          checks = 0;
  int          failures = 0;

  function automatic void chk(string name, logic [NR*DW-1:0] act, logic [NR*DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [NR*DW-1:0] image();
    logic [NR*DW-1:0] img;
    for (int i = 0; i < NR; i++) img[i*DW +: DW] = model[i];
    return img;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = RV[i*DW +: DW];
  endtask

  // Reference: word index from the byte address, masked merge of strobed bytes.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_t        e;
    logic [31:0] mask;
    int unsigned idx;
    idx = addr / 4;
    e.resp = 2'b00;
    e.pulse = '0;
    if (idx < NR) begin
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
      model[idx] = (model[idx] & ~mask) | (data & mask);
      if (strb != 4'h0) e.pulse = NR'(1) << idx;
    end else begin
      e.resp = OOR_RESP;
    end
    e.img = image();
    sb.push_back(e);
  endtask

  // bd < 0 leaves the response pending so the caller can interrupt it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int awd, input int wd, input int bd);
    logic aw_done;
    int   n;
    model_write(addr, data, strb);
    aw_done = 1'b0;
    bready = (bd == 0);
    fork
      begin
        logic hs;
        int   k;
        repeat (awd) begin @(posedge clk); #1; end
        awaddr = addr;
        awvalid = 1'b1;
        hs = 1'b0;
        k = 0;
        while (!hs && k < 50) begin
          @(negedge clk);
          hs = awready;
          @(posedge clk);
          #1;
          k++;
        end
        awvalid = 1'b0;
        aw_done = 1'b1;
        if (!hs) chk("aw_timeout", 0, 1);
      end
      begin
        logic hs;
        int   k;
        repeat (wd) begin @(posedge clk); #1; end
        wdata = data;
        wstrb = strb;
        wvalid = 1'b1;
        hs = 1'b0;
        k = 0;
        while (!hs && k < 50) begin
          @(negedge clk);
          hs = wready;
          @(posedge clk);
          #1;
          k++;
        end
        wvalid = 1'b0;
        if (!hs) chk("w_timeout", 0, 1);
        @(negedge clk);
        if (!aw_done) chk("wready_after_w", wready, 0);
      end
    join
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bvalid && n < 50);
    if (!bvalid) begin
      chk("b_timeout", 0, 1);
      bready = 1'b0;
    end else if (bd >= 0) begin
      if (!bready) begin
        repeat (bd - 1) @(negedge clk);
        bready = 1'b1;
      end
      @(posedge clk);
      #1;
      bready = 1'b0;
    end
  endtask

  // Monitor: pops an expectation whenever a fresh response appears.
  initial begin : checkOutput
    logic       prev;
    logic [1:0] held;
    exp_t       e;
    prev = 1'b0;
    held = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (bvalid && !prev) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_b actual=bvalid required=no_response");
          end else begin
            e = sb.pop_front();
            chk("bresp", bresp, e.resp);
            chk("regs_out", regs_out, e.img);
            chk("wr_pulse", wr_pulse, e.pulse);
          end
          held = bresp;
        end else begin
          chk("pulse_idle", wr_pulse, 0);
          if (bvalid) begin
            chk("bresp_hold", bresp, held);
            chk("ready_in_resp", {awready, wready}, 0);
          end
        end
        prev = bvalid;
      end
    end
  end

  initial begin
    logic [NR*DW-1:0] snap;
    logic [31:0]      addr;
    int               sel;
    rst = 1'b0;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_regs", regs_out, RV);
    chk("reset_bvalid", bvalid, 0);
    chk("reset_bresp", bresp, 0);
    chk("reset_pulse", wr_pulse, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {awready, wready}, 2'b11);
    @(posedge clk); #1;

    applyStimulus(32'h0, 32'h1122_3344, 4'hF, 0, 0, 0);
    chk("reg0_full", regs_out[0 +: 32], 32'h1122_3344);
    applyStimulus(32'h4, 32'hAABB_CCDD, 4'hF, 0, 0, 1);
    applyStimulus(32'h4, 32'h5566_7788, 4'b1011, 0, 0, 0);
    chk("reg1_strobed", regs_out[32 +: 32], 32'h55BB_7788);
    applyStimulus(32'h1C, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
    chk("reg7_w_first", regs_out[224 +: 32], 32'hDEAD_BEEF);
    applyStimulus(32'h1D, 32'h0000_0000, 4'hF, 0, 0, 0);
    applyStimulus(32'h1C, 32'hDEAD_BEEF, 4'hF, 0, 3, 0);
    chk("reg7_aw_first", regs_out[224 +: 32], 32'hDEAD_BEEF);
    applyStimulus(32'h8, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
    snap = regs_out;
    applyStimulus(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    chk("oor_no_change", regs_out, snap);
    applyStimulus(32'hC, 32'h1234_5678, 4'h0, 1, 0, 2);
    chk("zero_strb_reg3", regs_out[96 +: 32], RV[96 +: 32]);

    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 4);
      if (sel < 3) addr = $urandom_range(0, 31);
      else if (sel == 3) addr = 32 + $urandom_range(0, 31);
      else begin
        addr = $urandom;
        if (addr < 32) addr = addr + 32;
      end
      applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    applyStimulus(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, -1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk("midreset_bvalid", bvalid, 0);
    chk("midreset_regs", regs_out, RV);
    chk("midreset_pulse", wr_pulse, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    applyStimulus(32'h14, 32'h0102_0304, 4'hF, 0, 1, 1);
    chk("reg5_after_reset", regs_out[160 +: 32], 32'h0102_0304);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
